sensor_luz: RTL and testbench

Light-sensor acquisition stage feeding the lamp controller. Periodically (or on request) reads a 16-bit lux count from the serial light sensor and detects whether the sensor module is present. Converts the count to 5-digit BCD and holds it on `luxes`, the format the lamp controller compares by digit (`luxes[19:16]` = ten-thousands). Drives `modLuz`, which the lamp controller uses as its module-connected input.

---
 rtl/sensor_luz.sv | 188 ++++++++++++++++++
 tb/tb_sensor_luz.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_luz.sv
// Light-sensor acquisition: serial read of presence bit + 16-bit lux count, BCD conversion.
// Latency: IDLE exit to dato_valido = 35*CLK_DIV+17 cycles (present), 35*CLK_DIV+1 (absent).
// No backpressure: medir is accepted only in IDLE; requests while busy are dropped.
module sensor_luz #(
  parameter int CLK_DIV = 4,
  parameter int PERIODO = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        medir,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic [19:0] luxes,
  output logic        modLuz,
  output logic        dato_valido,
  output logic        ocupado
);

  localparam int PW = $clog2(PERIODO);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PER_MAX = PW'(PERIODO - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SHIFT = 3'd2,
    STOP  = 3'd3,
    CONV  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_per;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_bit;
  logic [3:0]      r_it;
  logic            r_aus;
  logic [15:0]     r_raw;
  logic [35:0]     r_dd;
  logic            r_cs_n;
  logic            r_sclk;
  logic [19:0]     r_luxes;
  logic            r_mod;
  logic            r_vld;
  logic            r_ocu;

  logic            w_start;
  logic [19:0]     w_adj;
  logic [35:0]     w_cat;
  logic [35:0]     w_dd_next;

  // A read begins from IDLE on an explicit request or when the period expires;
  // both in the same cycle still yield a single read.
  assign w_start = (r_state == IDLE) && (medir || (r_per == PER_MAX));

  // Period counter: restarts on each IDLE exit and saturates so a long read
  // leads straight into the next one once IDLE is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per <= '0;
    end else if (w_start) begin
      r_per <= '0;
    end else if (r_per != PER_MAX) begin
      r_per <= r_per + 1'b1;
    end
  end

  // Double-dabble step: add 3 to every BCD digit >= 5, then shift {bcd, raw} left.
  always_comb begin
    w_adj = r_dd[35:16];
    for (int d = 0; d < 5; d++) begin
      if (r_dd[16 + 4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_dd[16 + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_cat     = {w_adj, r_dd[15:0]};
  assign w_dd_next = w_cat << 1;

  // Main sequencer with registered serial-interface and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_it    <= '0;
      r_aus   <= 1'b0;
      r_raw   <= '0;
      r_dd    <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_luxes <= '0;
      r_mod   <= 1'b0;
      r_vld   <= 1'b0;
      r_ocu   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= START;
            r_cs_n  <= 1'b0;
            r_ocu   <= 1'b1;
            r_div   <= '0;
          end
        end
        START: begin
          // Chip select settles for one half-period; slot 0 rises at its end
          // and the presence bit is captured on that same edge.
          if (r_div == DIV_MAX) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b1;
            r_aus   <= miso;
            r_state <= SHIFT;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        SHIFT: begin
          // Each slot: high half-period then low half-period. Data is taken
          // on the rising edge of the next slot, MSB of raw first.
          if (r_div == DIV_MAX) begin
            r_div <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (r_bit == 5'd16) begin
              r_cs_n  <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit  <= r_bit + 1'b1;
              r_sclk <= 1'b1;
              r_raw  <= {r_raw[14:0], miso};
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        STOP: begin
          if (r_aus) begin
            // No sensor: report zero and skip the conversion.
            r_luxes <= '0;
            r_mod   <= 1'b0;
            r_vld   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_dd    <= {20'd0, r_raw};
            r_it    <= '0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_dd <= w_dd_next;
          if (r_it == 4'd15) begin
            // Final iteration result goes straight to the output register.
            r_luxes <= w_dd_next[35:16];
            r_mod   <= 1'b1;
            r_vld   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_it <= r_it + 1'b1;
          end
        end
        DONE: begin
          r_ocu   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_cs_n  <= 1'b1;
          r_sclk  <= 1'b0;
          r_ocu   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cs_n        = r_cs_n;
  assign sclk        = r_sclk;
  assign luxes       = r_luxes;
  assign modLuz      = r_mod;
  assign dato_valido = r_vld;
  assign ocupado     = r_ocu;

endmodule

// File: tb/tb_sensor_luz.sv
module tb_sensor_luz;

  localparam int CLK_DIV = 4;
  localparam int PERIODO = 200;
  localparam int LAT_P   = 35*CLK_DIV + 17;
  localparam int LAT_A   = 35*CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        medir;
  logic        miso;
  logic        cs_n;
  logic        sclk;
  logic [19:0] luxes;
  logic        modLuz;
  logic        dato_valido;
  logic        ocupado;

  int n_checks = 0;
  int n_fail   = 0;

  // Sensor model state
  bit          present = 1'b1;
  logic [15:0] raw     = 16'd0;
  int          sidx    = 0;
  logic        s_prev  = 1'b0;

  always #5 clk = ~clk;

  sensor_luz #(.CLK_DIV(CLK_DIV), .PERIODO(PERIODO)) dut (
    .clk         (clk),
    .rst         (rst),
    .medir       (medir),
    .miso        (miso),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .luxes       (luxes),
    .modLuz      (modLuz),
    .dato_valido (dato_valido),
    .ocupado     (ocupado)
  );

  // Serial light sensor: presence bit then raw MSB-first, advancing after each sclk fall.
  always @(negedge clk) begin
    if (cs_n !== 1'b0) sidx = 0;
    else if (s_prev === 1'b1 && sclk === 1'b0) sidx = sidx + 1;
    s_prev = sclk;
    if (!present)        miso = 1'b1;
    else if (sidx == 0)  miso = 1'b0;
    else if (sidx <= 16) miso = raw[16 - sidx];
    else                 miso = 1'b1;
  end

  function automatic logic [19:0] to_bcd(input int v);
    to_bcd = {4'(v / 10000), 4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    medir = 1'b1;
    @(posedge clk);
    #1;
    medir = 1'b0;
  endtask

  // Cycles from IDLE exit until dato_valido, plus sclk rising edges seen meanwhile.
  task automatic measure(output int lat, output int rises);
    logic prev;
    lat = 0; rises = 0; prev = sclk;
    while (dato_valido !== 1'b1 && lat < 400) begin
      tick();
      lat++;
      if (prev === 1'b0 && sclk === 1'b1) rises++;
      prev = sclk;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; medir = 1'b0;
    repeat (3) tick();
    n_checks++; if (cs_n !== 1'b1)        begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_checks++; if (sclk !== 1'b0)        begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    n_checks++; if (luxes !== 20'h0)      begin n_fail++; $display("FAIL reset_luxes: got %h expected 00000", luxes); end
    n_checks++; if (modLuz !== 1'b0)      begin n_fail++; $display("FAIL reset_modLuz: got %b expected 0", modLuz); end
    n_checks++; if (dato_valido !== 1'b0) begin n_fail++; $display("FAIL reset_dato_valido: got %b expected 0", dato_valido); end
    n_checks++; if (ocupado !== 1'b0)     begin n_fail++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_periodic();
    int n, lat, rises;
    present = 1'b1;
    raw = 16'($urandom);
    n = 0;
    while (cs_n !== 1'b0 && n < 400) begin tick(); n++; end
    n_checks++; if (n != PERIODO) begin n_fail++; $display("FAIL first_auto_start: got %0d edges expected %0d", n, PERIODO); end
    measure(lat, rises);
    n_checks++; if (lat != LAT_P) begin n_fail++; $display("FAIL auto_latency: got %0d expected %0d", lat, LAT_P); end
    n_checks++; if (rises != 17)  begin n_fail++; $display("FAIL auto_sclk_rises: got %0d expected 17", rises); end
    n_checks++; if (luxes !== to_bcd(int'(raw))) begin n_fail++; $display("FAIL auto_luxes: got %h expected %h", luxes, to_bcd(int'(raw))); end
    n_checks++; if (modLuz !== 1'b1) begin n_fail++; $display("FAIL auto_modLuz: got %b expected 1", modLuz); end
    n = lat;
    tick(); n++;
    n_checks++; if (dato_valido !== 1'b0) begin n_fail++; $display("FAIL vld_one_cycle: got %b expected 0", dato_valido); end
    n_checks++; if (ocupado !== 1'b0)     begin n_fail++; $display("FAIL idle_after_done: got %b expected 0", ocupado); end
    raw = 16'($urandom);
    while (cs_n !== 1'b0 && n < 400) begin tick(); n++; end
    n_checks++; if (n != PERIODO) begin n_fail++; $display("FAIL auto_restart_period: got %0d expected %0d", n, PERIODO); end
    measure(lat, rises);
    n_checks++; if (rises != 17)  begin n_fail++; $display("FAIL auto2_sclk_rises: got %0d expected 17", rises); end
    n_checks++; if (luxes !== to_bcd(int'(raw))) begin n_fail++; $display("FAIL auto2_luxes: got %h expected %h", luxes, to_bcd(int'(raw))); end
    tick();
  endtask

  task automatic test_medir_present();
    int lat, rises;
    present = 1'b1;
    raw = 16'd20000;
    kick();
    n_checks++; if (ocupado !== 1'b1) begin n_fail++; $display("FAIL ocupado_rise: got %b expected 1", ocupado); end
    n_checks++; if (cs_n !== 1'b0)    begin n_fail++; $display("FAIL cs_n_fall: got %b expected 0", cs_n); end
    measure(lat, rises);
    n_checks++; if (lat != LAT_P)        begin n_fail++; $display("FAIL medir_latency: got %0d expected %0d", lat, LAT_P); end
    n_checks++; if (luxes !== 20'h20000) begin n_fail++; $display("FAIL luxes_20000: got %h expected 20000", luxes); end
    n_checks++; if (modLuz !== 1'b1)     begin n_fail++; $display("FAIL modLuz_20000: got %b expected 1", modLuz); end
    tick();
  endtask

  task automatic test_values();
    int lat, rises;
    logic [15:0] vals [7];
    vals[0] = 16'd65535; vals[1] = 16'd19999; vals[2] = 16'd0;
    for (int i = 3; i < 7; i++) vals[i] = 16'($urandom);
    present = 1'b1;
    for (int i = 0; i < 7; i++) begin
      raw = vals[i];
      kick();
      measure(lat, rises);
      n_checks++; if (lat != LAT_P) begin n_fail++; $display("FAIL values_latency[%0d]: got %0d expected %0d", i, lat, LAT_P); end
      n_checks++; if (luxes !== to_bcd(int'(vals[i]))) begin n_fail++; $display("FAIL values_luxes[%0d]: raw %0d got %h expected %h", i, vals[i], luxes, to_bcd(int'(vals[i]))); end
      n_checks++; if (modLuz !== 1'b1) begin n_fail++; $display("FAIL values_modLuz[%0d]: got %b expected 1", i, modLuz); end
      tick();
    end
  endtask

  task automatic test_absent();
    int lat, rises;
    present = 1'b0;
    kick();
    measure(lat, rises);
    n_checks++; if (lat != LAT_A)   begin n_fail++; $display("FAIL absent_latency: got %0d expected %0d", lat, LAT_A); end
    n_checks++; if (rises != 17)    begin n_fail++; $display("FAIL absent_sclk_rises: got %0d expected 17", rises); end
    n_checks++; if (luxes !== 20'h0) begin n_fail++; $display("FAIL absent_luxes: got %h expected 00000", luxes); end
    n_checks++; if (modLuz !== 1'b0) begin n_fail++; $display("FAIL absent_modLuz: got %b expected 0", modLuz); end
    tick();
    present = 1'b1;
  endtask

  task automatic test_medir_ignored();
    int lat, rises, pulses;
    present = 1'b1;
    raw = 16'd1;
    kick();
    repeat (50) tick();
    medir = 1'b1;
    tick();
    medir = 1'b0;
    measure(lat, rises);
    n_checks++; if (51 + lat != LAT_P)   begin n_fail++; $display("FAIL busy_medir_latency: got %0d expected %0d", 51 + lat, LAT_P); end
    n_checks++; if (luxes !== 20'h00001) begin n_fail++; $display("FAIL busy_medir_luxes: got %h expected 00001", luxes); end
    pulses = 0;
    repeat (30) begin tick(); if (dato_valido === 1'b1) pulses++; end
    n_checks++; if (pulses != 0)      begin n_fail++; $display("FAIL busy_medir_queued: got %0d extra pulses expected 0", pulses); end
    n_checks++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL busy_medir_idle: got %b expected 0", ocupado); end
  endtask

  task automatic test_reset_mid();
    int lat, rises;
    present = 1'b1;
    raw = 16'd1234;
    kick();
    measure(lat, rises);
    n_checks++; if (luxes !== 20'h01234) begin n_fail++; $display("FAIL prior_luxes_1234: got %h expected 01234", luxes); end
    tick();
    raw = 16'($urandom);
    kick();
    repeat (60) tick();
    n_checks++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL pre_reset_sclk: got %b expected 1", sclk); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (cs_n !== 1'b1)        begin n_fail++; $display("FAIL midreset_cs_n: got %b expected 1", cs_n); end
    n_checks++; if (sclk !== 1'b0)        begin n_fail++; $display("FAIL midreset_sclk: got %b expected 0", sclk); end
    n_checks++; if (luxes !== 20'h0)      begin n_fail++; $display("FAIL midreset_luxes: got %h expected 00000", luxes); end
    n_checks++; if (modLuz !== 1'b0)      begin n_fail++; $display("FAIL midreset_modLuz: got %b expected 0", modLuz); end
    n_checks++; if (ocupado !== 1'b0)     begin n_fail++; $display("FAIL midreset_ocupado: got %b expected 0", ocupado); end
    n_checks++; if (dato_valido !== 1'b0) begin n_fail++; $display("FAIL midreset_dato_valido: got %b expected 0", dato_valido); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    raw = 16'($urandom);
    kick();
    measure(lat, rises);
    n_checks++; if (lat != LAT_P) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT_P); end
    n_checks++; if (luxes !== to_bcd(int'(raw))) begin n_fail++; $display("FAIL post_reset_luxes: got %h expected %h", luxes, to_bcd(int'(raw))); end
    n_checks++; if (modLuz !== 1'b1) begin n_fail++; $display("FAIL post_reset_modLuz: got %b expected 1", modLuz); end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    medir = 1'b0;
    test_reset();
    test_periodic();
    test_medir_present();
    test_values();
    test_absent();
    test_medir_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
